// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared constants for the register-file read arbiter slice.
//   NUM_REQ_DEFAULT : default number of requesters on the shared read port
//   SEL_WIDTH       : register address / read-mux select width (16 registers)
//   DATA_WIDTH      : register data width
//   REQ_*           : fixed requester slot assignments on req/grant/rd_valid
package regfile_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int SEL_WIDTH       = 4;
  localparam int DATA_WIDTH      = 32;

  localparam int REQ_FETCH = 0;
  localparam int REQ_ALU   = 1;
  localparam int REQ_STORE = 2;
  localparam int REQ_DEBUG = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Purely combinational round-robin picker. Finds the first asserted request
//   at or above rr_ptr, wrapping past the top back to index 0.
//   Ports:
//     req     in  NUM_REQ  request vector
//     rr_ptr  in  PTR_W    index holding highest priority this cycle
//     winner  out PTR_W    index of the selected requester (valid when any_req)
//     any_req out 1        at least one request is asserted
module rr_priority_picker
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  // Doubling the vector turns the rotate into a plain offset read.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     first_idx;
  logic [PTR_W:0]       idx_sum;

  assign req_dbl = {req, req};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign req_rot[gi] = req_dbl[{1'b0, rr_ptr} + (PTR_W+1)'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) first_idx = PTR_W'(i);
    end
  end

  // Unrotate: add rr_ptr back, modulo NUM_REQ (NUM_REQ need not be a power of 2).
  always_comb begin
    idx_sum = {1'b0, first_idx} + {1'b0, rr_ptr};
    if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
      idx_sum = idx_sum - (PTR_W+1)'(NUM_REQ);
    end
    winner = idx_sum[PTR_W-1:0];
  end

  assign any_req = |req;

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin arbiter/sequencer for a single shared register-file read port.
//   Stage 1 grants one requester per cycle and drives the read-mux select;
//   stage 2 captures the mux output one edge later, tagged with the owner.
//   Ports:
//     clk        in  1                   rising-edge clock
//     reset      in  1                   synchronous active-high reset
//     req        in  NUM_REQ             per-requester read request
//     req_addr   in  NUM_REQ*SEL_WIDTH   packed addresses, requester i at [i*SEL_WIDTH +: SEL_WIDTH]
//     stall      in  1                   blocks new grants (in-flight capture still completes)
//     mux_select out SEL_WIDTH           select to the 16-to-1 read mux
//     mux_data   in  DATA_WIDTH          combinational read-mux output
//     grant      out NUM_REQ             registered one-hot grant pulse
//     rd_valid   out NUM_REQ             registered one-hot owner of rd_data
//     rd_data    out DATA_WIDTH          registered captured register value
//     busy       out 1                   grant or rd_valid nonzero
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = regfile_arb_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = regfile_arb_pkg::SEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*SEL_WIDTH-1:0] req_addr,
  input  logic                         stall,
  output logic [SEL_WIDTH-1:0]         mux_select,
  input  logic [DATA_WIDTH-1:0]        mux_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W:0]       winner_inc;
  logic                 any_req;
  logic [NUM_REQ-1:0]   winner_onehot;
  logic [SEL_WIDTH-1:0] req_addr_arr [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_arr[gi]  = req_addr[gi*SEL_WIDTH +: SEL_WIDTH];
      assign winner_onehot[gi] = (winner == PTR_W'(gi));
    end
  endgenerate

  // Pointer moves to the slot just past the winner, wrapping at NUM_REQ.
  always_comb begin
    winner_inc = {1'b0, winner} + (PTR_W+1)'(1);
    if (winner_inc >= (PTR_W+1)'(NUM_REQ)) begin
      winner_inc = '0;
    end
    rr_ptr_next = winner_inc[PTR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      grant      <= '0;
      mux_select <= '0;
      rd_valid   <= '0;
      rd_data    <= '0;
    end else begin
      // Capture stage runs regardless of stall so an in-flight read completes.
      rd_valid <= grant;
      if (|grant) rd_data <= mux_data;

      if (any_req && !stall) begin
        grant      <= winner_onehot;
        mux_select <= req_addr_arr[winner];
        rr_ptr_reg <= rr_ptr_next;
      end else begin
        grant <= '0;
      end
    end
  end

  assign busy = (|grant) | (|rd_valid);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic        stall;
  logic [3:0]  mux_select;
  logic [31:0] mux_data;
  logic [3:0]  grant;
  logic [3:0]  rd_valid;
  logic [31:0] rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regfile_read_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .SEL_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .stall      (stall),
    .mux_select (mux_select),
    .mux_data   (mux_data),
    .grant      (grant),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Read-mux model: register n reads back as 32'hA5A5_000n.
  assign mux_data = 32'hA5A5_0000 | {28'd0, mux_select};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = 4'b0000;
    req_addr = 16'h0000;
    stall    = 1'b0;
    tick();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL reset_rd_valid got %b want 0000", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 00000000", rd_data); end
    checks++; if (mux_select !== 4'd0) begin errors++; $display("FAIL reset_mux_select got %0d want 0", mux_select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    $display("txn reset done");
  endtask

  task automatic test_single();
    reset    = 1'b0;
    req      = 4'b0001;
    req_addr = 16'h0005;
    tick();
    req = 4'b0000;
    $display("txn single grant=%b sel=%0d", grant, mux_select);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
    checks++; if (mux_select !== 4'd5) begin errors++; $display("FAIL single_sel got %0d want 5", mux_select); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want 1", busy); end
    tick();
    $display("txn single rd_valid=%b rd_data=%h", rd_valid, rd_data);
    checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL single_rd_valid got %b want 0001", rd_valid); end
    checks++; if (rd_data !== 32'hA5A5_0005) begin errors++; $display("FAIL single_rd_data got %h want a5a50005", rd_data); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_drop got %b want 0000", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b want 1", busy); end
    tick();
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL single_rd_valid_drop got %b want 0000", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  exp_sel   [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [3:0]  exp_valid [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] exp_data  [5] = '{32'h0, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    do_reset();
    req_addr = 16'h4321;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("txn rr cycle=%0d grant=%b sel=%0d rd_valid=%b rd_data=%h", i, grant, mux_select, rd_valid, rd_data);
      checks++; if (grant !== exp_grant[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, grant, exp_grant[i]); end
      checks++; if (mux_select !== exp_sel[i]) begin errors++; $display("FAIL rr_sel[%0d] got %0d want %0d", i, mux_select, exp_sel[i]); end
      checks++; if (rd_valid !== exp_valid[i]) begin errors++; $display("FAIL rr_rd_valid[%0d] got %b want %b", i, rd_valid, exp_valid[i]); end
      if (i > 0) begin
        checks++; if (rd_data !== exp_data[i]) begin errors++; $display("FAIL rr_rd_data[%0d] got %h want %h", i, rd_data, exp_data[i]); end
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    // rr_ptr is 1 here; a grant to requester 1 moves it to 2.
    req_addr = 16'h4321;
    req      = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_setup got %b want 0010", grant); end
    req = 4'b0011;
    tick();
    $display("txn wrap grant=%b", grant);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b want 0001", grant); end
    tick();
    $display("txn wrap grant=%b", grant);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b want 0010", grant); end
    req = 4'b1111;
    tick();
    $display("txn wrap ptr-probe grant=%b", grant);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wrap_ptr got %b want 0100", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req_addr = 16'h4321;
    req      = 4'b1111;
    tick();
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_setup got %b want 0010", grant); end
    stall = 1'b1;
    tick();
    $display("txn stall rd_valid=%b rd_data=%h grant=%b", rd_valid, rd_data, grant);
    checks++; if (rd_valid !== 4'b0010) begin errors++; $display("FAIL stall_capture got %b want 0010", rd_valid); end
    checks++; if (rd_data !== 32'hA5A5_0002) begin errors++; $display("FAIL stall_data got %h want a5a50002", rd_data); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_grant0 got %b want 0000", grant); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_hold_grant[%0d] got %b want 0000", i, grant); end
      checks++; if (mux_select !== 4'd2) begin errors++; $display("FAIL stall_hold_sel[%0d] got %0d want 2", i, mux_select); end
    end
    stall = 1'b0;
    tick();
    $display("txn stall-release grant=%b sel=%0d", grant, mux_select);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stall_resume got %b want 0100", grant); end
    checks++; if (mux_select !== 4'd3) begin errors++; $display("FAIL stall_resume_sel got %0d want 3", mux_select); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr = 16'h4321;
    req      = 4'b1111;
    tick();
    tick();
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_setup got %b want 0100", grant); end
    reset = 1'b1;
    tick();
    $display("txn reset-mid grant=%b rd_valid=%b rd_data=%h sel=%0d", grant, rd_valid, rd_data, mux_select);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_grant got %b want 0000", grant); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rmid_rd_valid got %b want 0000", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rmid_rd_data got %h want 00000000", rd_data); end
    checks++; if (mux_select !== 4'd0) begin errors++; $display("FAIL rmid_sel got %0d want 0", mux_select); end
    reset = 1'b0;
    tick();
    $display("txn reset-mid restart grant=%b rd_valid=%b", grant, rd_valid);
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rmid_no_stale_valid got %b want 0000", rd_valid); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_restart got %b want 0001", grant); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_addr = 16'h0000;
    stall    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
